// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle of the prefetch unit: memory request/response channel,
// instruction hand-off to the core and the core's redirect feedback.
interface ifu_prefetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, keeps a credit-limited stream of
// in-order fetches in flight and buffers returned words for the core.
module ifu_prefetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    ifu_prefetch_if.master bus
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW:0]   C_CAP  = CW1'(DEPTH);
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    logic [63:0]   fetch_pc_r;
    logic [63:0]   resp_pc_r;
    logic [63:0]   req_addr_r;
    logic          req_valid_r;
    logic          stale_r;
    logic [CW-1:0] occ_r;
    logic [CW-1:0] outst_r;
    logic [CW-1:0] drop_cnt_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic          inst_valid_r;
    logic [31:0]   inst_r;
    logic [63:0]   inst_pc_r;
    logic [31:0]   mem_inst_r [DEPTH];
    logic [63:0]   mem_pc_r   [DEPTH];

    logic          hs_s;
    logic          held_s;
    logic          redir_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          stale_hs_s;
    logic [63:0]   redir_pc_s;
    logic [63:0]   fetch_pc_nx_s;
    logic [63:0]   resp_pc_nx_s;
    logic [63:0]   req_addr_nx_s;
    logic          req_valid_nx_s;
    logic          stale_nx_s;
    logic [CW-1:0] occ_nx_s;
    logic [CW-1:0] outst_nx_s;
    logic [CW-1:0] drop_nx_s;
    logic [CW:0]   credit_sum_s;
    logic [PW-1:0] rd_nx_s;
    logic [PW-1:0] wr_nx_s;
    logic [31:0]   inst_nx_s;
    logic [63:0]   inst_pc_nx_s;

    // Per-cycle events; a redirect suppresses both the push and the pop
    always_comb begin
        hs_s       = req_valid_r & bus.req_ready;
        held_s     = req_valid_r & ~bus.req_ready;
        redir_s    = bus.redirect_valid;
        drop_s     = bus.resp_valid & (drop_cnt_r != C_ZERO);
        push_s     = bus.resp_valid & (drop_cnt_r == C_ZERO) & ~redir_s;
        pop_s      = inst_valid_r & bus.inst_ready & ~redir_s;
        stale_hs_s = hs_s & stale_r;
        redir_pc_s = bus.redirect_pc & ~64'h0000_0000_0000_0003;
    end

    // Next-state for counters, PCs and pointers
    always_comb begin
        outst_nx_s = outst_r;
        if (hs_s && !bus.resp_valid) begin
            outst_nx_s = outst_r + C_ONE;
        end else if (!hs_s && bus.resp_valid) begin
            outst_nx_s = outst_r - C_ONE;
        end else begin
            outst_nx_s = outst_r;
        end

        // After a redirect every request still owed a response is garbage,
        // including one accepted this very cycle.
        drop_nx_s = drop_cnt_r;
        if (redir_s) begin
            drop_nx_s = outst_nx_s;
        end else if (stale_hs_s && !drop_s) begin
            drop_nx_s = drop_cnt_r + C_ONE;
        end else if (!stale_hs_s && drop_s) begin
            drop_nx_s = drop_cnt_r - C_ONE;
        end else begin
            drop_nx_s = drop_cnt_r;
        end

        stale_nx_s = stale_r;
        if (redir_s) begin
            stale_nx_s = held_s;
        end else if (hs_s) begin
            stale_nx_s = 1'b0;
        end else begin
            stale_nx_s = stale_r;
        end

        fetch_pc_nx_s = fetch_pc_r;
        if (redir_s) begin
            fetch_pc_nx_s = redir_pc_s;
        end else if (hs_s && !stale_r) begin
            fetch_pc_nx_s = fetch_pc_r + 64'd4;
        end else begin
            fetch_pc_nx_s = fetch_pc_r;
        end

        // Surviving responses are always a sequential run from the last target
        resp_pc_nx_s = resp_pc_r;
        if (redir_s) begin
            resp_pc_nx_s = redir_pc_s;
        end else if (push_s) begin
            resp_pc_nx_s = resp_pc_r + 64'd4;
        end else begin
            resp_pc_nx_s = resp_pc_r;
        end

        occ_nx_s = occ_r;
        rd_nx_s  = rd_ptr_r;
        wr_nx_s  = wr_ptr_r;
        if (redir_s) begin
            occ_nx_s = C_ZERO;
            rd_nx_s  = P_ZERO;
            wr_nx_s  = P_ZERO;
        end else begin
            if (push_s && !pop_s) begin
                occ_nx_s = occ_r + C_ONE;
            end else if (pop_s && !push_s) begin
                occ_nx_s = occ_r - C_ONE;
            end else begin
                occ_nx_s = occ_r;
            end
            rd_nx_s = pop_s  ? rd_ptr_r + P_ONE : rd_ptr_r;
            wr_nx_s = push_s ? wr_ptr_r + P_ONE : wr_ptr_r;
        end

        credit_sum_s   = {1'b0, occ_nx_s} + {1'b0, outst_nx_s};
        req_valid_nx_s = held_s | (credit_sum_s < C_CAP);
        req_addr_nx_s  = held_s ? req_addr_r : fetch_pc_nx_s;
    end

    // Next FIFO head; a push into an otherwise-empty FIFO feeds the head directly
    always_comb begin
        inst_nx_s    = 32'h0000_0000;
        inst_pc_nx_s = 64'h0000_0000_0000_0000;
        if (occ_nx_s == C_ZERO) begin
            inst_nx_s    = 32'h0000_0000;
            inst_pc_nx_s = 64'h0000_0000_0000_0000;
        end else if (push_s && (wr_ptr_r == rd_nx_s)) begin
            inst_nx_s    = bus.resp_data;
            inst_pc_nx_s = resp_pc_r;
        end else begin
            inst_nx_s    = mem_inst_r[rd_nx_s];
            inst_pc_nx_s = mem_pc_r[rd_nx_s];
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r   <= RESET_PC;
            resp_pc_r    <= RESET_PC;
            req_addr_r   <= RESET_PC;
            req_valid_r  <= 1'b0;
            stale_r      <= 1'b0;
            occ_r        <= C_ZERO;
            outst_r      <= C_ZERO;
            drop_cnt_r   <= C_ZERO;
            rd_ptr_r     <= P_ZERO;
            wr_ptr_r     <= P_ZERO;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= 64'h0000_0000_0000_0000;
        end else begin
            fetch_pc_r   <= fetch_pc_nx_s;
            resp_pc_r    <= resp_pc_nx_s;
            req_addr_r   <= req_addr_nx_s;
            req_valid_r  <= req_valid_nx_s;
            stale_r      <= stale_nx_s;
            occ_r        <= occ_nx_s;
            outst_r      <= outst_nx_s;
            drop_cnt_r   <= drop_nx_s;
            rd_ptr_r     <= rd_nx_s;
            wr_ptr_r     <= wr_nx_s;
            inst_valid_r <= (occ_nx_s != C_ZERO);
            inst_r       <= inst_nx_s;
            inst_pc_r    <= inst_pc_nx_s;
        end
    end

    // FIFO storage; a slot's contents only matter while it is occupied
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_inst_r[wr_ptr_r] <= bus.resp_data;
            mem_pc_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

    assign bus.req_valid  = req_valid_r;
    assign bus.req_addr   = req_addr_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = inst_pc_r;
endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized scoreboard bench for ifu_prefetch: an in-order memory model and a
// request/instruction-stream reference model drive expectations.
module tb_ifu_prefetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          DEPTH    = 4;
    localparam int          NCYC     = 4000;

    typedef struct {
        logic [63:0] addr;
        bit          live;
        int          ready_cyc;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    req_t outst_q[$];
    ent_t exp_q[$];

    ifu_prefetch_if bus();

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                check("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
                if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pop_empty: got pc %h with nothing expected", bus.inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_pc", bus.inst_pc, e.pc);
                        check("inst", 64'(bus.inst), 64'(e.inst));
                        n_pop++;
                    end
                end
            end
        end
    end

    // Stimulus, memory model and request-side reference model
    initial begin
        logic [63:0] model_pc;
        logic [63:0] p_addr;
        logic [63:0] p_rpc;
        bit          held_dead;
        bit          p_rst, p_rv, p_rr, p_resp, p_redir;
        bit          exp_rv;
        req_t        p_ent;
        int unsigned rdy_pct, irdy_pct, redir_pct, lat_max;

        rst                = 1'b1;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = 32'h0000_0000;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        model_pc  = RESET_PC;
        held_dead = 1'b0;
        p_rst = 1'b1; p_rv = 1'b0; p_rr = 1'b0; p_resp = 1'b0; p_redir = 1'b0;
        p_addr = 64'h0; p_rpc = 64'h0;
        p_ent = '{addr: 64'h0, live: 1'b0, ready_cyc: 0};
        rdy_pct = 100; irdy_pct = 100; redir_pct = 0; lat_max = 1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // account for what happened in the previous cycle
            if (p_rst) begin
                outst_q.delete();
                exp_q.delete();
                model_pc  = RESET_PC;
                held_dead = 1'b0;
                check("rst_req_valid", 64'(bus.req_valid), 64'(0));
                check("rst_req_addr", bus.req_addr, RESET_PC);
                check("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
                check("rst_inst", 64'(bus.inst), 64'(0));
                check("rst_inst_pc", bus.inst_pc, 64'h0);
            end else begin
                if (p_resp && !p_redir && p_ent.live) begin
                    exp_q.push_back('{pc: p_ent.addr, inst: mem_word(p_ent.addr)});
                end
                if (p_rv && p_rr) begin
                    if (!held_dead) begin
                        check("req_addr", p_addr, model_pc);
                        model_pc = model_pc + 64'd4;
                    end
                    outst_q.push_back('{addr: p_addr, live: !held_dead && !p_redir,
                                        ready_cyc: cyc - 1 + int'($urandom_range(lat_max, 1))});
                    held_dead = 1'b0;
                    check("outst_bound", 64'(outst_q.size() <= DEPTH), 64'(1));
                end
                if (p_redir) begin
                    foreach (outst_q[i]) outst_q[i].live = 1'b0;
                    exp_q.delete();
                    model_pc = p_rpc & ~64'h3;
                    if (p_rv && !p_rr) held_dead = 1'b1;
                end
                exp_rv = (p_rv && !p_rr) || ((exp_q.size() + outst_q.size()) < DEPTH);
                check("req_valid", 64'(bus.req_valid), 64'(exp_rv));
                if (p_rv && !p_rr) begin
                    check("req_addr_hold", bus.req_addr, p_addr);
                end
            end

            if (cyc < 60) begin
                rdy_pct = 100; lat_max = 1; irdy_pct = 100; redir_pct = 0;
            end else if (cyc < 100) begin
                rdy_pct = 100; lat_max = 1; irdy_pct = 0;   redir_pct = 0;
            end else if (cyc < 140) begin
                rdy_pct = 100; lat_max = 1; irdy_pct = 100; redir_pct = 0;
            end else if (cyc < 200) begin
                rdy_pct = 0;   lat_max = 1; irdy_pct = 100; redir_pct = 10;
            end else if (cyc < 2000) begin
                rdy_pct = 70;  lat_max = 4; irdy_pct = 70;  redir_pct = 4;
            end else begin
                rdy_pct = 50;  lat_max = 3; irdy_pct = 80;  redir_pct = 15;
            end

            rst = (cyc < 3) || (cyc == 2000) || (cyc == 2001);
            if (rst) begin
                bus.req_ready      = 1'b0;
                bus.resp_valid     = 1'b0;
                bus.inst_ready     = 1'b0;
                bus.redirect_valid = 1'b0;
            end else begin
                bus.req_ready = ($urandom_range(99) < rdy_pct);
                if (outst_q.size() != 0 && outst_q[0].ready_cyc <= cyc) begin
                    p_ent          = outst_q.pop_front();
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = mem_word(p_ent.addr);
                end else begin
                    bus.resp_valid = 1'b0;
                    bus.resp_data  = $urandom;
                end
                bus.inst_ready     = ($urandom_range(99) < irdy_pct);
                bus.redirect_valid = ($urandom_range(99) < redir_pct);
                if ($urandom_range(15) == 0) begin
                    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
                end else begin
                    bus.redirect_pc = 64'h8000_0000 + 64'($urandom_range(4095));
                end
            end

            p_rst   = rst;
            p_rv    = bus.req_valid;
            p_rr    = bus.req_ready;
            p_addr  = bus.req_addr;
            p_resp  = bus.resp_valid;
            p_redir = bus.redirect_valid;
            p_rpc   = bus.redirect_pc;
        end

        check("pops_seen", 64'(n_pop > 500), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Instruction fetch unit directly upstream of the single-cycle RV64 core. It owns the fetch PC, issues in-order instruction-fetch requests to memory over a valid/ready request channel plus an in-order response channel, and buffers returned instructions in a DEPTH-entry FIFO. It presents one {inst, inst_pc} pair per cycle to the core. The core's taken branch/jump is fed back as a redirect that flushes the buffer and all in-flight fetches.

Parameters:
RESET_PC  64'h0000000080000000  fetch PC loaded on reset
DEPTH  4  FIFO entries; also the cap on FIFO occupancy plus outstanding requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_addr  out  64  fetch address, 4-byte aligned
resp_valid  in  1  response valid; always accepted, responses return in request order
resp_data  in  32  instruction word
inst_valid  out  1  FIFO head valid
inst_ready  in  1  core consumes head
inst  out  32  head instruction
inst_pc  out  64  head PC
redirect_valid  in  1  core branch/jump taken
redirect_pc  in  64  new fetch target; bits [1:0] ignored (treated as 0)

Behaviour:
- State: fetch_pc (64b), FIFO of {pc,inst} x DEPTH, occ and outst counters ($clog2(DEPTH+1) bits), drop_cnt (same width), stale flag for a held request.
- Reset: fetch_pc=RESET_PC, FIFO empty, occ=outst=drop_cnt=0, stale=0. All outputs reset: req_valid=0, inst_valid=0, inst=0, inst_pc=0, req_addr=RESET_PC.
- Reset mid-operation clears all state. The memory model is reset by the same rst, so no pre-reset responses return.
- Issue: req_valid=1 when occ+outst<DEPTH, or when a request is already held. req_addr=fetch_pc.
- Valid/ready rule: once req_valid is high it stays high, and req_addr stays stable, until req_valid&req_ready.
- Request handshake: outst+1. fetch_pc+=4 (64-bit wrap) unless the request is stale. If stale, it is counted into drop_cnt and stale clears.
- Response: outst-1. If drop_cnt>0, discard the response and drop_cnt-1. Otherwise push {pc of that request, resp_data}. PC is tracked in a parallel pc FIFO or recomputed; implementation choice.
- inst_valid = occ>0, registered FIFO head. Latency resp_valid -> inst_valid is 1 cycle; no bypass.
- Pop on inst_valid&inst_ready.
- Simultaneous push and pop keeps occ unchanged. Push is guaranteed never to overflow by the credit rule.
- Steady state with zero-wait memory (req_ready=1, response the cycle after acceptance) and inst_ready=1: one instruction per cycle.
- Redirect (redirect_valid=1), takes priority over all same-cycle events:
  - FIFO cleared, occ=0. A same-cycle pop is irrelevant.
  - fetch_pc <= {redirect_pc[63:2],2'b00}.
  - A same-cycle response is discarded.
  - drop_cnt <= outst - resp_valid + (req_valid&req_ready).
  - If req_valid&!req_ready, the held request stays on the bus with its old address and stale=1. Its response is dropped via drop_cnt once accepted. The next new request uses the redirect PC.
  - Back-to-back redirects: the latest wins; drop_cnt is recomputed from the current outst.
- outst never exceeds DEPTH. drop_cnt<=outst always. Verification asserts both, plus occ<=DEPTH.

Test Plan:
- Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> req_addr 0x80000000, 0x80000004, ... on consecutive cycles; inst_pc 0x80000000 first valid 2 cycles after first handshake, then one per cycle.
- inst_ready=0, zero-wait memory -> exactly 4 handshakes (0x80000000..0x8000000C), then req_valid=0. occ=4. Raise inst_ready -> head pc 0x80000000, fetch resumes at 0x80000010.
- 2 requests outstanding (3-cycle memory), redirect_pc=0x80000103 -> next 2 responses dropped. First inst_pc=0x80000100, inst=word at 0x80000100.
- req_ready=0 holding 0x80000008, redirect to 0x80000200 -> req_addr stays 0x80000008 until accepted. Its response is never output. Next req_addr=0x80000200.
- Redirect same cycle as resp_valid and inst_ready with occ=3 -> occ=0, inst_valid=0 next cycle, response discarded, outst decremented.
- rst pulsed mid-stream with occ=2, outst=2 -> next cycle inst_valid=0, req_valid=0. First request after release is 0x80000000.
